framebuffer_dblbuf: RTL

- Single-clock, double-buffered framebuffer. Two pixel banks:
  - Front bank: read by the video output path.
  - Back bank: written by the drawing logic.
- Bank swap is requested at any time and executes only at a frame boundary, so the displayed image never tears.
- Built-in clear engine fills the back bank with a constant colour.
- Reads use display (x,y) coordinates; the block downscales them internally by SCALING_FACTOR.

---
 rtl/framebuffer_dblbuf.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_dblbuf.sv
// Double-buffered framebuffer: tear-free bank swap at frame boundaries,
// back-bank clear engine and a 2-cycle display read pipeline.
module framebuffer_dblbuf #(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int SCALING_FACTOR = 1,
    parameter int DATA_WIDTH     = 8,
    parameter int COORD_WIDTH    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [COORD_WIDTH-1:0] wr_x,
    input  logic [COORD_WIDTH-1:0] wr_y,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_ready,
    input  logic                   clear_req,
    input  logic [DATA_WIDTH-1:0]  clear_color,
    output logic                   clear_busy,
    input  logic                   swap_req,
    output logic                   swap_pending,
    input  logic                   frame_start,
    output logic                   front_sel,
    input  logic                   rd_en,
    input  logic [COORD_WIDTH-1:0] rd_x,
    input  logic [COORD_WIDTH-1:0] rd_y,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid
);
    localparam int BW   = FRAME_WIDTH / SCALING_FACTOR;
    localparam int BH   = FRAME_HEIGHT / SCALING_FACTOR;
    localparam int N    = BW * BH;
    localparam int AW   = (N > 1) ? $clog2(N) : 1;
    localparam int SH   = $clog2(SCALING_FACTOR);
    localparam int MAXD = (FRAME_WIDTH > FRAME_HEIGHT) ?
                          FRAME_WIDTH : FRAME_HEIGHT;
    localparam int CW1  = COORD_WIDTH + 1;

    localparam logic [CW1-1:0] FW_C = CW1'(FRAME_WIDTH);
    localparam logic [CW1-1:0] FH_C = CW1'(FRAME_HEIGHT);
    localparam logic [CW1-1:0] BW_C = CW1'(BW);
    localparam logic [CW1-1:0] BH_C = CW1'(BH);
    localparam logic [AW-1:0]  LAST = AW'(N - 1);

    generate
        if (SCALING_FACTOR != 1 && SCALING_FACTOR != 2 &&
            SCALING_FACTOR != 4 && SCALING_FACTOR != 8) begin : g_bad_scale
            $error("SCALING_FACTOR must be 1, 2, 4 or 8");
        end
        if ((64'd1 << COORD_WIDTH) < 64'(MAXD)) begin : g_bad_coord
            $error("COORD_WIDTH too narrow for the frame size");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_nx;
    logic [AW-1:0]           count, count_nx;
    logic [DATA_WIDTH-1:0]   color;
    logic                    target;

    logic [DATA_WIDTH-1:0]   mem [2][N];
    logic                    mem_we;
    logic                    mem_bank;
    logic [AW-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]   mem_din;

    logic                    wr_in;
    logic [AW-1:0]           wr_addr;
    logic [COORD_WIDTH-1:0]  rd_sx, rd_sy;
    logic                    rd_in;
    logic [AW-1:0]           rd_addr;

    logic                    s1_valid;
    logic                    s1_bank;
    logic                    s1_in;
    logic [AW-1:0]           s1_addr;

    assign clear_busy = (state == CLEAR);
    assign wr_ready   = ~clear_busy;

    assign wr_in   = ({1'b0, wr_x} < BW_C) && ({1'b0, wr_y} < BH_C);
    assign wr_addr = AW'(wr_y) * AW'(BW) + AW'(wr_x);

    assign rd_sx   = rd_x >> SH;
    assign rd_sy   = rd_y >> SH;
    assign rd_in   = ({1'b0, rd_x} < FW_C) && ({1'b0, rd_y} < FH_C) &&
                     ({1'b0, rd_sx} < BW_C) && ({1'b0, rd_sy} < BH_C);
    assign rd_addr = AW'(rd_sy) * AW'(BW) + AW'(rd_sx);

    // Clear FSM state register plus latched fill colour and target bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            color  <= '0;
            target <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (state == IDLE && clear_req) begin
                color  <= clear_color;
                target <= ~front_sel;
            end
        end
    end

    // Clear FSM next state: walk every address once, then go idle
    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nx = CLEAR;
                    count_nx = '0;
                end
            end
            CLEAR: begin
                count_nx = count + AW'(1);
                if (count == LAST) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            end
        endcase
    end

    // Single write port: clear engine owns it while busy
    always_comb begin
        mem_we   = 1'b0;
        mem_bank = ~front_sel;
        mem_addr = wr_addr;
        mem_din  = wr_data;
        if (clear_busy) begin
            mem_we   = 1'b1;
            mem_bank = target;
            mem_addr = count;
            mem_din  = color;
        end else if (wr_en && wr_in) begin
            mem_we = 1'b1;
        end
    end

    // Pixel storage for both banks, contents not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_bank][mem_addr] <= mem_din;
        end
    end

    // Swap control: toggle only on a frame boundary outside a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (frame_start && (swap_pending || swap_req) &&
                     !clear_busy) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // Read stage 1: capture address, bank and range flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bank  <= 1'b0;
            s1_in    <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_bank <= front_sel;
                s1_in   <= rd_in;
                s1_addr <= rd_addr;
            end
        end
    end

    // Read stage 2: register RAM output, zero for off-screen reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
                rd_data <= s1_in ? mem[s1_bank][s1_addr] : '0;
            end
        end
    end

endmodule
